// File: rtl/exponent_bias_pipe.sv
// Two-stage exponent bias pipeline: per-channel remove/add/pass bias with range flags.
// Optional macro SUBNORMAL_EXP_ADJUST_EN: a zero field in remove mode yields 1-BIAS.

module exponent_bias_lane #(
  parameter int EXP_WIDTH = 8,
  parameter int BIAS      = 2**(EXP_WIDTH-1)-1
) (
  input  logic [1:0]           mode_i,
  input  logic [EXP_WIDTH+1:0] exp_i,
  output logic [EXP_WIDTH+1:0] res_o,
  output logic                 is_zero_o,
  output logic                 is_max_o,
  output logic                 ovf_o,
  output logic                 unf_o
);
  localparam int W  = EXP_WIDTH + 2;
  localparam int XW = W + 2;
  localparam logic [W-1:0]         BIAS_W  = W'(BIAS);
  localparam logic signed [XW-1:0] BIAS_X  = XW'(BIAS);
  localparam logic signed [XW-1:0] OVF_LIM = XW'(2**EXP_WIDTH - 1);
  localparam logic signed [XW-1:0] ZERO_X  = '0;

  logic [EXP_WIDTH-1:0]   field;
  logic [W-1:0]           rem;
  logic signed [XW-1:0]   sum;

  // sum is kept two bits wider so the flags see the true value before wrapping
  assign field = exp_i[EXP_WIDTH-1:0];
  assign rem   = {2'b00, field} - BIAS_W;
  assign sum   = $signed({{2{exp_i[W-1]}}, exp_i}) + BIAS_X;

  always_comb begin
    res_o     = exp_i;
    is_zero_o = 1'b0;
    is_max_o  = 1'b0;
    ovf_o     = 1'b0;
    unf_o     = 1'b0;
    case (mode_i)
      2'b01: begin
        res_o     = rem;
`ifdef SUBNORMAL_EXP_ADJUST_EN
        if (field == '0) res_o = W'(1 - BIAS);
`endif
        is_zero_o = (field == '0);
        is_max_o  = &field;
      end
      2'b10: begin
        res_o = sum[W-1:0];
        ovf_o = (sum >= OVF_LIM);
        unf_o = (sum <= ZERO_X);
      end
      default: begin
        is_zero_o = (field == '0);
        is_max_o  = &field;
      end
    endcase
  end
endmodule

module exponent_bias_pipe #(
  parameter int EXP_WIDTH = 8,
  parameter int BIAS      = 2**(EXP_WIDTH-1)-1,
  parameter int CHANNELS  = 2,
  parameter int TAG_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [1:0]                           in_mode,
  input  logic [CHANNELS*(EXP_WIDTH+2)-1:0]    in_exp,
  input  logic [TAG_WIDTH-1:0]                 in_tag,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [CHANNELS*(EXP_WIDTH+2)-1:0]    out_exp,
  output logic [CHANNELS-1:0]                  out_is_zero,
  output logic [CHANNELS-1:0]                  out_is_max,
  output logic [CHANNELS-1:0]                  out_ovf,
  output logic [CHANNELS-1:0]                  out_unf,
  output logic [TAG_WIDTH-1:0]                 out_tag
);
  localparam int W = EXP_WIDTH + 2;

  typedef struct packed {
    logic [CHANNELS-1:0][W-1:0] exp;
    logic [CHANNELS-1:0]        zero;
    logic [CHANNELS-1:0]        max;
    logic [CHANNELS-1:0]        ovf;
    logic [CHANNELS-1:0]        unf;
    logic [TAG_WIDTH-1:0]       tag;
  } stage_t;

  logic [CHANNELS-1:0][W-1:0] lane_exp;
  logic [CHANNELS-1:0]        lane_zero, lane_max, lane_ovf, lane_unf;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    exponent_bias_lane #(.EXP_WIDTH(EXP_WIDTH), .BIAS(BIAS)) u_lane (
      .mode_i    (in_mode),
      .exp_i     (in_exp[g*W +: W]),
      .res_o     (lane_exp[g]),
      .is_zero_o (lane_zero[g]),
      .is_max_o  (lane_max[g]),
      .ovf_o     (lane_ovf[g]),
      .unf_o     (lane_unf[g])
    );
  end

  stage_t     s1_d, s1_q, s2_q;
  logic [2:1] vld_q;
  logic       s2_load, accept;

  always_comb begin
    s1_d      = '0;
    s1_d.exp  = lane_exp;
    s1_d.zero = lane_zero;
    s1_d.max  = lane_max;
    s1_d.ovf  = lane_ovf;
    s1_d.unf  = lane_unf;
    s1_d.tag  = in_tag;
  end

  // in_ready only depends on out_ready combinationally, never on in_valid
  assign s2_load  = !vld_q[2] || out_ready;
  assign in_ready = !vld_q[1] || s2_load;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
    end else begin
      if (in_ready) vld_q[1] <= in_valid;
      if (s2_load)  vld_q[2] <= vld_q[1];
    end
  end

  // Data registers only toggle on a real advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      if (accept)              s1_q <= s1_d;
      if (s2_load && vld_q[1]) s2_q <= s1_q;
    end
  end

  assign out_valid   = vld_q[2];
  assign out_exp     = s2_q.exp;
  assign out_is_zero = s2_q.zero;
  assign out_is_max  = s2_q.max;
  assign out_ovf     = s2_q.ovf;
  assign out_unf     = s2_q.unf;
  assign out_tag     = s2_q.tag;
endmodule

// File: tb/tb_exponent_bias_pipe.sv
// Scoreboard bench for exponent_bias_pipe (EXP_WIDTH=8, BIAS=127, CHANNELS=2).

module tb_exponent_bias_pipe;
  localparam int W  = 10;
  localparam int CH = 2;

  typedef struct packed {
    logic [CH*W-1:0] e;
    logic [CH-1:0]   z, m, o, u;
    logic [3:0]      tag;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      in_mode = '0;
  logic [CH*W-1:0] in_exp = '0;
  logic [3:0]      in_tag = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [CH*W-1:0] out_exp;
  logic [CH-1:0]   out_is_zero, out_is_max, out_ovf, out_unf;
  logic [3:0]      out_tag;

  int   errors = 0;
  int   checks = 0;
  int   popped = 0;
  int   rdy_low_seen = 0;
  bit   done = 0;
  exp_t sb[$];

  exponent_bias_pipe dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_exp(in_exp), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_exp(out_exp), .out_is_zero(out_is_zero),
    .out_is_max(out_is_max), .out_ovf(out_ovf), .out_unf(out_unf), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] md, input logic [W-1:0] e0,
                                 input logic [W-1:0] e1, input logic [3:0] tg);
    exp_t        r;
    logic [W-1:0] ea [CH];
    int          f, v, t;
    logic [31:0] tv;
    r = '0;
    r.tag = tg;
    ea[0] = e0;
    ea[1] = e1;
    for (int c = 0; c < CH; c++) begin
      f = int'(ea[c][7:0]);
      case (md)
        2'b01: begin
          t = f - 127;
`ifdef SUBNORMAL_EXP_ADJUST_EN
          if (f == 0) t = -126;
`endif
          r.z[c] = (f == 0);
          r.m[c] = (f == 255);
        end
        2'b10: begin
          v = ea[c][W-1] ? int'(ea[c]) - 1024 : int'(ea[c]);
          t = v + 127;
          r.o[c] = (t >= 255);
          r.u[c] = (t <= 0);
        end
        default: begin
          t = int'(ea[c]);
          r.z[c] = (f == 0);
          r.m[c] = (f == 255);
        end
      endcase
      tv = t;
      r.e[c*W +: W] = tv[W-1:0];
    end
    return r;
  endfunction

  // Scoreboard monitor plus handshake and hold-stability observation
  bit              prev_stall = 0;
  logic [CH*W-1:0] prev_e;
  logic [3:0]      prev_tag;
  logic [4*CH-1:0] prev_f;
  always @(negedge clk) begin
    exp_t x;
    logic exp_rdy;
    if (!reset_n) begin
      prev_stall = 0;
    end else begin
      exp_rdy = !(sb.size() == 2 && !out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL in_ready: got %b want %b (occupancy %0d)", in_ready, exp_rdy, sb.size());
      end
      if (in_ready === 1'b0) rdy_low_seen++;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_exp !== prev_e || out_tag !== prev_tag ||
            {out_is_zero, out_is_max, out_ovf, out_unf} !== prev_f) begin
          errors++;
          $display("FAIL hold: got v=%b e=%h t=%h want v=1 e=%h t=%h", out_valid, out_exp, out_tag, prev_e, prev_tag);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got tag %h want no output", out_tag);
        end else begin
          x = sb.pop_front();
          popped++;
          if (out_exp !== x.e || out_is_zero !== x.z || out_is_max !== x.m ||
              out_ovf !== x.o || out_unf !== x.u || out_tag !== x.tag) begin
            errors++;
            $display("FAIL scoreboard: got e=%h z=%b m=%b o=%b u=%b t=%h want e=%h z=%b m=%b o=%b u=%b t=%h",
                     out_exp, out_is_zero, out_is_max, out_ovf, out_unf, out_tag,
                     x.e, x.z, x.m, x.o, x.u, x.tag);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_e     = out_exp;
      prev_tag   = out_tag;
      prev_f     = {out_is_zero, out_is_max, out_ovf, out_unf};
    end
  end

  // Starts and ends at posedge+1; expected value pushed when the beat is accepted
  task automatic send(input logic [1:0] md, input logic [W-1:0] e0,
                      input logic [W-1:0] e1, input logic [3:0] tg);
    bit acc = 0;
    in_valid = 1'b1;
    in_mode  = md;
    in_exp   = {e1, e0};
    in_tag   = tg;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk); #2;
      acc = (in_ready === 1'b1);
      if (acc) sb.push_back(model(md, e0, e1, tg));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles want accept (tag %h)", tg);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_exp !== '0 || out_tag !== '0 ||
        {out_is_zero, out_is_max, out_ovf, out_unf} !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b e=%h t=%h want all zero", out_valid, out_exp, out_tag);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_remove();
    logic [W-1:0] zexp;
`ifdef SUBNORMAL_EXP_ADJUST_EN
    zexp = 10'h382;
`else
    zexp = 10'h381;
`endif
    out_ready = 1'b1;
    send(2'b01, 10'h080, 10'h07F, 4'h1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL remove_latency1: got out_valid %b want 0", out_valid);
    end
    idle(1);
    checks++;
    if (out_valid !== 1'b1 || out_exp !== {10'h000, 10'h001} ||
        {out_is_zero, out_is_max, out_ovf, out_unf} !== '0) begin
      errors++;
      $display("FAIL remove_basic: got v=%b e=%h want v=1 e=%h flags 0", out_valid, out_exp, {10'h000, 10'h001});
    end
    idle(2);
    send(2'b01, 10'h000, 10'h0FF, 4'h2);
    idle(1);
    checks++;
    if (out_exp !== {10'h080, zexp} || out_is_zero !== 2'b01 || out_is_max !== 2'b10) begin
      errors++;
      $display("FAIL remove_special: got e=%h z=%b m=%b want e=%h z=01 m=10", out_exp, out_is_zero, out_is_max, {10'h080, zexp});
    end
    idle(2);
  endtask

  task automatic test_add();
    send(2'b10, 10'h080, 10'h381, 4'h3);
    idle(1);
    checks++;
    if (out_exp !== {10'h000, 10'h0FF} || out_ovf !== 2'b01 || out_unf !== 2'b10 ||
        out_is_zero !== 2'b00 || out_is_max !== 2'b00) begin
      errors++;
      $display("FAIL add_range: got e=%h o=%b u=%b want e=%h o=01 u=10", out_exp, out_ovf, out_unf, {10'h000, 10'h0FF});
    end
    idle(2);
    send(2'b10, 10'h000, 10'h000, 4'h4);
    idle(1);
    checks++;
    if (out_exp !== {10'h07F, 10'h07F} || {out_is_zero, out_is_max, out_ovf, out_unf} !== '0) begin
      errors++;
      $display("FAIL add_zero: got e=%h o=%b u=%b want e=%h flags 0", out_exp, out_ovf, out_unf, {10'h07F, 10'h07F});
    end
    idle(2);
  endtask

  task automatic test_pass();
    for (int k = 0; k < 2; k++) begin
      send(k == 0 ? 2'b00 : 2'b11, 10'h1A3, 10'h1A3, 4'(5 + k));
      idle(1);
      checks++;
      if (out_exp !== {10'h1A3, 10'h1A3} || out_ovf !== 2'b00 || out_unf !== 2'b00 ||
          out_is_zero !== 2'b00 || out_is_max !== 2'b00) begin
        errors++;
        $display("FAIL pass_mode%0d: got e=%h o=%b u=%b want e=%h flags 0", k, out_exp, out_ovf, out_unf, {10'h1A3, 10'h1A3});
      end
      idle(2);
    end
  endtask

  task automatic test_back_to_back();
    int p0 = popped;
    int l0 = rdy_low_seen;
    done = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(2'($urandom_range(0, 3)), 10'($urandom), 10'($urandom), 4'(i));
        done = 1;
      end
      begin
        for (int c = 0; c < 300 && (!done || sb.size() != 0); c++) begin
          out_ready = (c % 3 == 0);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    checks++;
    if (popped - p0 != 8 || sb.size() != 0) begin
      errors++;
      $display("FAIL stream_count: got %0d outputs (%0d pending) want 8 (0 pending)", popped - p0, sb.size());
    end
    checks++;
    if (rdy_low_seen == l0) begin
      errors++;
      $display("FAIL stream_backpressure: got in_ready never low want at least one low cycle");
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(2'b01, 10'h011, 10'h022, 4'h8);
    send(2'b10, 10'h033, 10'h044, 4'h9);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_pipe: got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_exp !== '0 || out_tag !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got v=%b e=%h t=%h rdy=%b want 0 0 0 1", out_valid, out_exp, out_tag, in_ready);
    end
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
    send(2'b01, 10'h0A0, 10'h07F, 4'hA);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_latency1: got out_valid %b want 0", out_valid);
    end
    idle(1);
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'hA || out_exp !== {10'h000, 10'h021}) begin
      errors++;
      $display("FAIL post_reset_latency2: got v=%b t=%h e=%h want 1 a %h", out_valid, out_tag, out_exp, {10'h000, 10'h021});
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_remove();
    test_add();
    test_pass();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
